// File: rtl/i_buf_ds_ctrl.sv
// Enable sequencer and output conditioner for one differential input buffer.
// It powers the buffer up, waits out the settle time, then synchronizes, deglitches and watches for loss of signal.
module i_buf_ds_ctrl #(
    parameter int SETTLE_CYCLES = 16,
    parameter int FILTER_CYCLES = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int LOS_CYCLES    = 1024
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ENABLE_REQ,
    input  logic       BUF_O,
    output logic       BUF_EN,
    output logic       DATA_OUT,
    output logic       VALID,
    output logic       LOS,
    output logic [1:0] dbg_state
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int FLT_W = $clog2(FILTER_CYCLES + 1);
    localparam int LOS_W = (LOS_CYCLES > 0) ? $clog2(LOS_CYCLES + 1) : 1;

    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [FLT_W-1:0] FILT_LAST   = FLT_W'(FILTER_CYCLES - 1);
    localparam logic [LOS_W-1:0] LOS_LAST    = LOS_W'((LOS_CYCLES > 0) ? LOS_CYCLES - 1 : 0);
    localparam logic [LOS_W-1:0] LOS_MAX     = LOS_W'(LOS_CYCLES);

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SETTLE = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t             state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SET_W-1:0]   settle_cnt;
    logic [FLT_W-1:0]   filter_cnt;
    logic [LOS_W-1:0]   los_cnt;
    logic               s;
    logic               data_update;

    initial begin
        if (SETTLE_CYCLES < 1 || FILTER_CYCLES < 1 || SYNC_STAGES < 2 || SYNC_STAGES > 4)
            $fatal(1, "%m: illegal parameter set");
    end

    assign s           = sync_q[SYNC_STAGES-1];
    assign data_update = (s != DATA_OUT) && (filter_cnt == FILT_LAST);
    assign dbg_state   = state;

    // The synchronizer runs regardless of state so S is already clean when settle completes.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) sync_q <= '0;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], BUF_O};
    end

    // VALID is a level qualifier, not a handshake: DATA_OUT is usable on every cycle VALID is high
    // and there is no back-pressure.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= OFF;
            BUF_EN     <= 1'b0;
            DATA_OUT   <= 1'b0;
            VALID      <= 1'b0;
            LOS        <= 1'b0;
            settle_cnt <= '0;
            filter_cnt <= '0;
            los_cnt    <= '0;
        end else if (state != OFF && !ENABLE_REQ) begin
            // Dropping the request beats settle completion, filter updates and LOS.
            state      <= OFF;
            BUF_EN     <= 1'b0;
            DATA_OUT   <= 1'b0;
            VALID      <= 1'b0;
            LOS        <= 1'b0;
            settle_cnt <= '0;
            filter_cnt <= '0;
            los_cnt    <= '0;
        end else begin
            case (state)
                OFF: begin
                    BUF_EN <= 1'b0;
                    if (ENABLE_REQ) begin
                        state      <= SETTLE;
                        BUF_EN     <= 1'b1;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state      <= ACTIVE;
                        VALID      <= 1'b1;
                        DATA_OUT   <= s;
                        filter_cnt <= '0;
                        los_cnt    <= '0;
                        LOS        <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (data_update) begin
                        DATA_OUT   <= s;
                        filter_cnt <= '0;
                        los_cnt    <= '0;
                        LOS        <= 1'b0;
                    end else begin
                        if (s != DATA_OUT) filter_cnt <= filter_cnt + 1'b1;
                        else               filter_cnt <= '0;
                        if (LOS_CYCLES > 0) begin
                            if (los_cnt != LOS_MAX) los_cnt <= los_cnt + 1'b1;
                            if (los_cnt == LOS_LAST) LOS <= 1'b1;
                        end
                    end
                end
                default: state <= OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_i_buf_ds_ctrl.sv
// Bench for i_buf_ds_ctrl: two instances (LOS enabled / disabled) share stimulus;
// expected output changes are queued with their edge number and checked by a monitor.
module tb_i_buf_ds_ctrl;

    logic clk;
    logic rst_n;
    logic enable_req;
    logic buf_o;
    logic buf_en0, data0, valid0, los0;
    logic buf_en1, data1, valid1, los1;
    logic [1:0] dbg0, dbg1;
    logic [7:0] mon_vec;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    bit mon_en = 0;
    logic [39:0] exp_q[$];

    i_buf_ds_ctrl #(.SETTLE_CYCLES(16), .FILTER_CYCLES(3), .SYNC_STAGES(2), .LOS_CYCLES(1024)) dut0 (
        .CLK(clk), .RST(rst_n), .ENABLE_REQ(enable_req), .BUF_O(buf_o),
        .BUF_EN(buf_en0), .DATA_OUT(data0), .VALID(valid0), .LOS(los0), .dbg_state(dbg0)
    );

    i_buf_ds_ctrl #(.SETTLE_CYCLES(16), .FILTER_CYCLES(3), .SYNC_STAGES(2), .LOS_CYCLES(0)) dut1 (
        .CLK(clk), .RST(rst_n), .ENABLE_REQ(enable_req), .BUF_O(buf_o),
        .BUF_EN(buf_en1), .DATA_OUT(data1), .VALID(valid1), .LOS(los1), .dbg_state(dbg1)
    );

    assign mon_vec = {buf_en0, valid0, data0, los0, buf_en1, valid1, data1, los1};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ev(input logic en, input logic v, input logic d,
                                      input logic l0, input logic l1);
        return {en, v, d, l0, en, v, d, l1};
    endfunction

    task automatic push(input int at_cyc, input logic [7:0] outs);
        exp_q.push_back({at_cyc[31:0], outs});
    endtask

    task automatic check_now(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%b want=%b", name, got, want);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [7:0] prev_vec;
    logic [7:0] cur_vec;
    logic [39:0] e;

    always @(negedge clk) begin
        if (mon_en) begin
            cur_vec = mon_vec;
            total++;
            if ((valid0 && !buf_en0) || (valid1 && !buf_en1)) begin
                bad++;
                $display("FAIL valid_implies_en: cyc=%0d got=%b", cyc, cur_vec);
            end
            if (cur_vec !== prev_vec) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: cyc=%0d got=%b prev=%b", cyc, cur_vec, prev_vec);
                end else begin
                    e = exp_q.pop_front();
                    if (cur_vec !== e[7:0] || cyc != int'(e[39:8])) begin
                        bad++;
                        $display("FAIL output_change: got=%b at cyc=%0d, want=%b at cyc=%0d",
                                 cur_vec, cyc, e[7:0], int'(e[39:8]));
                    end
                end
            end
            prev_vec = cur_vec;
        end
    end

    // ---------------- stimulus ----------------
    int t;

    initial begin
        rst_n = 1'b0;
        enable_req = 1'b1;
        buf_o = 1'b0;

        // Reset held with request high and BUF_O toggling
        for (int i = 0; i < 6; i++) begin
            tick(1);
            buf_o = ~buf_o;
        end
        buf_o = 1'b0;
        tick(2);
        check_now("reset_outs", mon_vec, 8'h00);
        prev_vec = mon_vec;
        mon_en = 1'b1;

        // Release: BUF_EN next edge, VALID 16 edges later with DATA_OUT=0
        t = cyc;
        push(t + 1, ev(1, 0, 0, 0, 0));
        push(t + 17, ev(1, 1, 0, 0, 0));
        rst_n = 1'b1;
        tick(20);

        // Clean rising and falling edges: 2 sync + 3 filter cycles
        t = cyc; buf_o = 1'b1; push(t + 5, ev(1, 1, 1, 0, 0)); tick(10);
        t = cyc; buf_o = 1'b0; push(t + 5, ev(1, 1, 0, 0, 0)); tick(10);

        // Two-cycle pulse is filtered out
        buf_o = 1'b1; tick(2); buf_o = 1'b0; tick(10);

        // Three-cycle pulse just passes and returns
        t = cyc; buf_o = 1'b1;
        push(t + 5, ev(1, 1, 1, 0, 0));
        push(t + 8, ev(1, 1, 0, 0, 0));
        tick(3); buf_o = 1'b0; tick(12);

        // LOS asserts 1024 edges after the last DATA_OUT change, clears on the next change
        t = cyc; buf_o = 1'b1;
        push(t + 5, ev(1, 1, 1, 0, 0));
        push(t + 1029, ev(1, 1, 1, 1, 0));
        tick(1035);
        t = cyc; buf_o = 1'b0; push(t + 5, ev(1, 1, 0, 0, 0)); tick(10);

        // Bring LOS up again, then reset asynchronously between edges
        t = cyc; buf_o = 1'b1;
        push(t + 5, ev(1, 1, 1, 0, 0));
        push(t + 1029, ev(1, 1, 1, 1, 0));
        tick(1035);
        t = cyc;
        push(t, ev(0, 0, 0, 0, 0));
        #2 rst_n = 1'b0;
        #1 check_now("async_reset", mon_vec, 8'h00);
        tick(2);

        // Fresh full settle after release; DATA_OUT picks up BUF_O=1 at qualification
        t = cyc;
        push(t + 1, ev(1, 0, 0, 0, 0));
        push(t + 17, ev(1, 1, 1, 0, 0));
        rst_n = 1'b1;
        tick(25);

        // Shutdown from ACTIVE
        t = cyc; enable_req = 1'b0; push(t + 1, ev(0, 0, 0, 0, 0)); tick(5);

        // Shutdown on the very edge settle would complete: VALID never rises
        t = cyc; enable_req = 1'b1;
        push(t + 1, ev(1, 0, 0, 0, 0));
        push(t + 17, ev(0, 0, 0, 0, 0));
        tick(16); enable_req = 1'b0; tick(5);

        // 1->0->1 mid-settle restarts the full 16-edge settle
        t = cyc; enable_req = 1'b1;
        push(t + 1, ev(1, 0, 0, 0, 0));
        tick(6); enable_req = 1'b0;
        push(t + 7, ev(0, 0, 0, 0, 0));
        tick(1); enable_req = 1'b1;
        t = cyc;
        push(t + 1, ev(1, 0, 0, 0, 0));
        push(t + 17, ev(1, 1, 1, 0, 0));
        tick(17);

        // Static line for 5000 cycles: only the LOS-enabled instance flags it
        t = cyc;
        push(t + 1024, ev(1, 1, 1, 1, 0));
        tick(5000);
        check_now("los_disabled_static", {6'b0, valid1, los1}, 8'b0000_0010);
        tick(3);

        mon_en = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_change: got=none want=%b at cyc=%0d", e[7:0], int'(e[39:8]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i_buf_ds_ctrl.md
Name: i_buf_ds_ctrl

Overview:
- Sequences the enable of one differential input buffer (I_BUF_DS) and conditions its output for fabric logic.
- Powers the buffer up on request and waits a fixed settle time before qualifying data.
- Synchronizes and deglitches the buffer output, and flags loss of signal when the line stops toggling.
- Sits in fabric between the I/O primitive and user logic; one instance per differential pair.

Parameters:
SETTLE_CYCLES, 16, cycles BUF_EN held high before data is qualified (1..65535)
FILTER_CYCLES, 3, consecutive identical synchronized samples needed to change DATA_OUT (1..255)
SYNC_STAGES, 2, flop stages synchronizing BUF_O into CLK domain (2..4)
LOS_CYCLES, 1024, cycles without DATA_OUT change before LOS asserts; 0 disables LOS (0..2^20-1)

Ports:
CLK  input  1  controller clock
RST  input  1  asynchronous active-low reset
ENABLE_REQ  input  1  level request to enable the buffer; 0 forces shutdown
BUF_O  input  1  O output of the differential buffer (asynchronous to CLK)
BUF_EN  output  1  drives EN of the differential buffer (registered)
DATA_OUT  output  1  synchronized, filtered data
VALID  output  1  DATA_OUT qualified
LOS  output  1  loss of signal while ACTIVE

Behaviour:
- Reset (RST=0, asynchronous): state OFF; BUF_EN=0, DATA_OUT=0, VALID=0, LOS=0; all counters and sync flops 0. Release is synchronous to the next CLK rising edge.
- Sync chain: SYNC_STAGES flops on BUF_O; the last stage is the sample S. The chain runs in all states.
- Counters: settle, filter and LOS counters are sized with $clog2(param+1) and saturate, never wrap.
- State OFF:
  - BUF_EN=0.
  - ENABLE_REQ=1 sampled at edge t: go to SETTLE, BUF_EN=1 from edge t, settle counter cleared.
- State SETTLE:
  - Settle counter increments each edge.
  - When the counter reaches SETTLE_CYCLES: go to ACTIVE, VALID=1, DATA_OUT=S, filter and LOS counters cleared.
  - VALID therefore rises SETTLE_CYCLES edges after BUF_EN rises.
- State ACTIVE:
  - S != DATA_OUT: filter counter increments. When it reaches FILTER_CYCLES: DATA_OUT<=S, filter counter cleared, LOS counter cleared, LOS<=0.
  - S == DATA_OUT: filter counter cleared. A single-sample glitch shorter than FILTER_CYCLES never propagates.
  - Latency from a clean BUF_O edge to DATA_OUT is SYNC_STAGES+FILTER_CYCLES cycles, ±1 for sampling phase.
  - LOS (LOS_CYCLES>0): LOS counter increments each edge without a DATA_OUT change. LOS<=1 when it reaches LOS_CYCLES; LOS stays high until the next DATA_OUT change.
  - LOS does not affect VALID or BUF_EN.
- Shutdown:
  - ENABLE_REQ=0 sampled in SETTLE or ACTIVE: next edge go to OFF; BUF_EN=0, VALID=0, LOS=0, DATA_OUT=0, counters cleared.
  - Shutdown has priority over every simultaneous event (settle completion, filter update, LOS).
- Re-request:
  - ENABLE_REQ toggling 1→0→1 always restarts the full settle period; there is no partial credit.
- Invariant: VALID=1 implies BUF_EN=1.
- Parameter check: an initial block issues $fatal(1,...) with instance %m if SETTLE_CYCLES=0, FILTER_CYCLES=0, or SYNC_STAGES is outside 2..4.

Test Plan:
- Reset values: hold RST=0 with ENABLE_REQ=1 and BUF_O toggling → all outputs 0. Release RST → BUF_EN=1 one edge later; VALID=1 exactly 16 edges after BUF_EN rose.
- Filter latency: ACTIVE with DATA_OUT=0, drive BUF_O 0→1 (steady) → DATA_OUT=1 after 5 cycles (2 sync + 3 filter, ±1). A 2-cycle high pulse on BUF_O → DATA_OUT stays 0.
- LOS: LOS_CYCLES=1024, hold BUF_O=1 → LOS=1 at 1024 edges after the last DATA_OUT change. Toggle BUF_O → LOS=0 on the edge DATA_OUT changes.
- Shutdown priority: deassert ENABLE_REQ on the same edge the settle count completes → state OFF, VALID never pulses. Deassert in ACTIVE → BUF_EN, VALID, DATA_OUT, LOS all 0 next edge.
- Async reset mid-operation: assert RST between clock edges during ACTIVE with LOS=1 → outputs 0 immediately, without waiting for an edge. After release, a fresh 16-cycle settle occurs.
- LOS disabled: LOS_CYCLES=0, BUF_O static for 5000 cycles → LOS remains 0, VALID remains 1.
